// File: rtl/ghost_draw_ctrl_pkg.sv
// ghost_draw_ctrl_pkg
//   Shared definitions for the ghost redraw controller: FSM state encoding,
//   tile/pixel coordinate widths and the default ghost colours.
package ghost_draw_ctrl_pkg;

  // Tile coordinates delivered by the path stages
  localparam int COORD_X_W = 5;
  localparam int COORD_Y_W = 4;

  // Pixel coordinates driven to the frame-buffer plotter
  localparam int PIX_X_W = 8;
  localparam int PIX_Y_W = 7;

  localparam int COL_W = 3;

  // Default colours
  localparam logic [COL_W-1:0] DEF_COL_G1 = 3'b100;
  localparam logic [COL_W-1:0] DEF_COL_G2 = 3'b101;
  localparam logic [COL_W-1:0] DEF_COL_G3 = 3'b011;
  localparam logic [COL_W-1:0] DEF_COL_BG = 3'b000;

  localparam int NUM_GHOSTS = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADV   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERASE = 3'd3,
    ST_DRAW  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/ghost_draw_ctrl_tile_raster.sv
// ghost_draw_ctrl_tile_raster
//   Walks one TILE x TILE tile in raster order (px fastest) and produces the
//   pixel coordinate for the current step plus a last-pixel flag.
// Ports:
//   clock, resetn        - clock, async active-low reset
//   i_start              - restart the walk at pixel (0,0)
//   i_step               - advance one pixel (wraps to (0,0) after the last)
//   i_base_x / i_base_y  - tile coordinates of the tile being walked
//   o_pix_x / o_pix_y    - pixel coordinate of the current step
//   o_last               - current step is the final pixel of the tile
module ghost_draw_ctrl_tile_raster
  import ghost_draw_ctrl_pkg::*;
#(
  parameter int TILE = 5
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 i_start,
  input  logic                 i_step,
  input  logic [COORD_X_W-1:0] i_base_x,
  input  logic [COORD_Y_W-1:0] i_base_y,
  output logic [PIX_X_W-1:0]   o_pix_x,
  output logic [PIX_Y_W-1:0]   o_pix_y,
  output logic                 o_last
);

  localparam int CW = (TILE > 1) ? $clog2(TILE) : 1;

  logic [CW-1:0] r_px;
  logic [CW-1:0] r_py;
  logic          w_px_end;
  logic          w_py_end;

  assign w_px_end = (r_px == CW'(TILE - 1));
  assign w_py_end = (r_py == CW'(TILE - 1));

  // In-tile pixel counters; wrapping after the last pixel lets ERASE flow
  // straight into DRAW without an extra restart cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_px <= CW'(0);
      r_py <= CW'(0);
    end else if (i_start) begin
      r_px <= CW'(0);
      r_py <= CW'(0);
    end else if (i_step) begin
      if (w_px_end) begin
        r_px <= CW'(0);
        r_py <= w_py_end ? CW'(0) : r_py + CW'(1);
      end else begin
        r_px <= r_px + CW'(1);
        r_py <= r_py;
      end
    end else begin
      r_px <= r_px;
      r_py <= r_py;
    end
  end

  // Unsigned pixel arithmetic; maxima with TILE=5 are 159 / 79
  assign o_pix_x = PIX_X_W'(i_base_x) * PIX_X_W'(TILE) + PIX_X_W'(r_px);
  assign o_pix_y = PIX_Y_W'(i_base_y) * PIX_Y_W'(TILE) + PIX_Y_W'(r_py);
  assign o_last  = w_px_end & w_py_end;

endmodule

// File: rtl/ghost_draw_ctrl.sv
// ghost_draw_ctrl
//   On each accepted step_tick: strobes the three ghost path stages, waits for
//   their new tile positions, then for each ghost erases the old tile and
//   draws the new one, one pixel per cycle, and finally pulses done.
//   Optional feature macro: GHOST_SKIP_UNCHANGED_EN - a ghost whose new
//   position equals its valid old position is neither erased nor redrawn.
// Ports:
//   clock, resetn            - clock, async active-low reset
//   step_tick                - advance request (only honoured in IDLE)
//   g1_x..g3_x, g1_y..g3_y   - ghost tile coordinates from the path stages
//   path_enable              - one-cycle advance strobe to the path stages
//   vga_x, vga_y, vga_colour - registered plot pixel and colour
//   vga_plot                 - registered pixel write strobe
//   busy                     - controller is not in IDLE
//   done                     - one-cycle pulse at the end of a redraw
module ghost_draw_ctrl
  import ghost_draw_ctrl_pkg::*;
#(
  parameter int               TILE   = 5,
  parameter logic [COL_W-1:0] COL_G1 = DEF_COL_G1,
  parameter logic [COL_W-1:0] COL_G2 = DEF_COL_G2,
  parameter logic [COL_W-1:0] COL_G3 = DEF_COL_G3,
  parameter logic [COL_W-1:0] COL_BG = DEF_COL_BG
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 step_tick,
  input  logic [COORD_X_W-1:0] g1_x,
  input  logic [COORD_X_W-1:0] g2_x,
  input  logic [COORD_X_W-1:0] g3_x,
  input  logic [COORD_Y_W-1:0] g1_y,
  input  logic [COORD_Y_W-1:0] g2_y,
  input  logic [COORD_Y_W-1:0] g3_y,
  output logic                 path_enable,
  output logic [PIX_X_W-1:0]   vga_x,
  output logic [PIX_Y_W-1:0]   vga_y,
  output logic [COL_W-1:0]     vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 done
);

  state_e r_state;
  state_e w_next;
  state_e w_entry;

  logic                 r_wait_cnt;
  logic [1:0]           r_idx;
  logic [COORD_X_W-1:0] r_old_x [NUM_GHOSTS];
  logic [COORD_Y_W-1:0] r_old_y [NUM_GHOSTS];
  logic [COORD_X_W-1:0] r_new_x [NUM_GHOSTS];
  logic [COORD_Y_W-1:0] r_new_y [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] r_old_valid;

  logic [1:0]           w_tgt_idx;
  logic [COORD_X_W-1:0] w_tgt_new_x;
  logic [COORD_Y_W-1:0] w_tgt_new_y;
  logic                 w_tgt_valid;
  logic                 w_wait_exit;
  logic                 w_plotting;
  logic                 w_raster_start;
  logic [COORD_X_W-1:0] w_base_x;
  logic [COORD_Y_W-1:0] w_base_y;
  logic [COL_W-1:0]     w_ghost_col;
  logic [PIX_X_W-1:0]   w_pix_x;
  logic [PIX_Y_W-1:0]   w_pix_y;
  logic                 w_last;

  assign w_wait_exit = (r_state == ST_WAIT) && r_wait_cnt;

  ghost_draw_ctrl_tile_raster #(
    .TILE (TILE)
  ) u_tile_raster (
    .clock    (clock),
    .resetn   (resetn),
    .i_start  (w_raster_start),
    .i_step   (w_plotting),
    .i_base_x (w_base_x),
    .i_base_y (w_base_y),
    .o_pix_x  (w_pix_x),
    .o_pix_y  (w_pix_y),
    .o_last   (w_last)
  );

  // Ghost about to be started: ghost 0 straight out of WAIT (its position is
  // taken from the inputs being latched on this edge), else the next index.
  always_comb begin
    w_tgt_idx   = r_idx + 2'd1;
    w_tgt_new_x = r_new_x[w_tgt_idx];
    w_tgt_new_y = r_new_y[w_tgt_idx];
    if (r_state == ST_WAIT) begin
      w_tgt_idx   = 2'd0;
      w_tgt_new_x = g1_x;
      w_tgt_new_y = g1_y;
    end else begin
      w_tgt_idx   = r_idx + 2'd1;
      w_tgt_new_x = r_new_x[w_tgt_idx];
      w_tgt_new_y = r_new_y[w_tgt_idx];
    end
    w_tgt_valid = r_old_valid[w_tgt_idx];
  end

  // First state for the target ghost: no erase until an old tile exists
  always_comb begin
    w_entry = ST_DRAW;
`ifdef GHOST_SKIP_UNCHANGED_EN
    if (w_tgt_valid && (w_tgt_new_x == r_old_x[w_tgt_idx]) &&
        (w_tgt_new_y == r_old_y[w_tgt_idx])) begin
      w_entry = ST_NEXT;
    end else if (w_tgt_valid) begin
      w_entry = ST_ERASE;
    end else begin
      w_entry = ST_DRAW;
    end
`else
    if (w_tgt_valid) begin
      w_entry = ST_ERASE;
    end else begin
      w_entry = ST_DRAW;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = step_tick ? ST_ADV : ST_IDLE;
      ST_ADV:   w_next = ST_WAIT;
      ST_WAIT:  w_next = r_wait_cnt ? w_entry : ST_WAIT;
      ST_ERASE: w_next = w_last ? ST_DRAW : ST_ERASE;
      ST_DRAW:  w_next = w_last ? ST_NEXT : ST_DRAW;
      ST_NEXT:  w_next = (r_idx == 2'd2) ? ST_DONE : w_entry;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM output decode (all taken from the state register)
  always_comb begin
    busy           = (r_state != ST_IDLE);
    done           = (r_state == ST_DONE);
    path_enable    = (r_state == ST_ADV);
    w_plotting     = (r_state == ST_ERASE) || (r_state == ST_DRAW);
    w_raster_start = !w_plotting;
  end

  // Raster base tile and draw colour for the current ghost
  always_comb begin
    w_base_x = r_new_x[r_idx];
    w_base_y = r_new_y[r_idx];
    if (r_state == ST_ERASE) begin
      w_base_x = r_old_x[r_idx];
      w_base_y = r_old_y[r_idx];
    end else begin
      w_base_x = r_new_x[r_idx];
      w_base_y = r_new_y[r_idx];
    end
    case (r_idx)
      2'd0:    w_ghost_col = COL_G1;
      2'd1:    w_ghost_col = COL_G2;
      default: w_ghost_col = COL_G3;
    endcase
  end

  // WAIT cycle counter and ghost index
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt <= 1'b0;
      r_idx      <= 2'd0;
    end else begin
      r_wait_cnt <= (r_state == ST_WAIT) ? ~r_wait_cnt : 1'b0;
      if (w_wait_exit) begin
        r_idx <= 2'd0;
      end else if ((r_state == ST_NEXT) && (r_idx != 2'd2)) begin
        r_idx <= r_idx + 2'd1;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // New-position latch at WAIT exit, new->old copy at the end of each DRAW
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        r_old_x[i] <= COORD_X_W'(0);
        r_old_y[i] <= COORD_Y_W'(0);
        r_new_x[i] <= COORD_X_W'(0);
        r_new_y[i] <= COORD_Y_W'(0);
      end
      r_old_valid <= 3'b000;
    end else begin
      if (w_wait_exit) begin
        r_new_x[0] <= g1_x;
        r_new_y[0] <= g1_y;
        r_new_x[1] <= g2_x;
        r_new_y[1] <= g2_y;
        r_new_x[2] <= g3_x;
        r_new_y[2] <= g3_y;
      end
      if ((r_state == ST_DRAW) && w_last) begin
        r_old_x[r_idx]     <= r_new_x[r_idx];
        r_old_y[r_idx]     <= r_new_y[r_idx];
        r_old_valid[r_idx] <= 1'b1;
      end
    end
  end

  // Registered plot port: strobe and pixel travel together
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_plot   <= 1'b0;
      vga_x      <= PIX_X_W'(0);
      vga_y      <= PIX_Y_W'(0);
      vga_colour <= COL_W'(0);
    end else if (w_plotting) begin
      vga_plot   <= 1'b1;
      vga_x      <= w_pix_x;
      vga_y      <= w_pix_y;
      vga_colour <= (r_state == ST_ERASE) ? COL_BG : w_ghost_col;
    end else begin
      vga_plot   <= 1'b0;
      vga_x      <= vga_x;
      vga_y      <= vga_y;
      vga_colour <= vga_colour;
    end
  end

endmodule

// File: doc/ghost_draw_ctrl.md
GHOST_DRAW_CTRL -- requirements
Module: ghost_draw_ctrl

Interface
REQ-001 SHALL have parameter TILE, default 5: tile edge in pixels.
REQ-002 SHALL have parameter COL_G1 / COL_G2 / COL_G3, defaults 3'b100 / 3'b101 / 3'b011: ghost colours.
REQ-003 SHALL have parameter COL_BG, default 3'b000: erase colour.
REQ-004 SHALL have port clock, input, 1: sole clock, all state on rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port step_tick, input, 1: request to advance all ghosts one path step.
REQ-007 SHALL have ports g1_x / g2_x / g3_x, input, 5 each: ghost tile column from the path stages.
REQ-008 SHALL have ports g1_y / g2_y / g3_y, input, 4 each: ghost tile row from the path stages.
REQ-009 SHALL have port path_enable, output, 1: one-cycle advance strobe to all three path stages.
REQ-010 SHALL have port vga_x, output, 8: plot pixel column.
REQ-011 SHALL have port vga_y, output, 7: plot pixel row.
REQ-012 SHALL have port vga_colour, output, 3: plot colour.
REQ-013 SHALL have port vga_plot, output, 1: pixel write strobe.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a full redraw completes.

Function
REQ-016 SHALL implement states IDLE, ADV, WAIT, ERASE, DRAW, NEXT, DONE.
REQ-017 SHALL move IDLE->ADV on step_tick=1, and SHALL ignore and drop step_tick in all other states.
REQ-018 SHALL assert path_enable exactly one cycle, in ADV only; ADV->WAIT.
REQ-019 SHALL hold WAIT 2 cycles to cover path-stage address update plus synchronous ROM latency, then latch all six g*_x/g*_y into new-position registers and go to ERASE with ghost index 0.
REQ-020 In ERASE, SHALL plot TILE*TILE pixels of COL_BG at the ghost's old position, one per cycle, raster order (px fastest), vga_x = old_x*TILE+px, vga_y = old_y*TILE+py.
REQ-021 In DRAW, SHALL plot TILE*TILE pixels of the ghost colour at the new position, in the same order, then copy new to old.
REQ-022 In NEXT, SHALL increment the ghost index: index<2 -> ERASE; index=2 -> DONE.
REQ-023 In DONE, SHALL pulse done for 1 cycle, then return to IDLE.
REQ-024 SHALL assert vga_plot only in cycles carrying a valid ERASE/DRAW pixel, and vga_x/vga_y/vga_colour SHALL be registered alongside it.
REQ-025 Pixel arithmetic SHALL be unsigned; with TILE=5 the maxima are x=159 and y=79, which fit without truncation.
REQ-026 SHALL skip ERASE for a ghost whose old position is not yet valid (first step after reset), going directly to DRAW.
REQ-027 Total latency, with default TILE and nothing skipped, SHALL be step_tick accept -> done = 1+2+150+3+1 cycles, with done at cycle 157 after the accepting edge.

Reset
REQ-028 On resetn=0, SHALL immediately enter IDLE and clear busy, done, path_enable, vga_plot, vga_x, vga_y, vga_colour, the counters, the ghost index, and the old/new registers, and SHALL clear all old-valid flags.
REQ-029 Reset mid-ERASE/DRAW SHALL abort the draw with no further plots; the first step after release behaves per REQ-026.

Configuration
REQ-030 With GHOST_SKIP_UNCHANGED_EN defined, a ghost whose latched new position equals its valid old position SHALL bypass ERASE and DRAW (0 plots) and go to NEXT.
REQ-031 Without GHOST_SKIP_UNCHANGED_EN, every ghost SHALL be erased and redrawn on every step.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, COORD_X_W=5, COORD_Y_W=4, PIX_X_W=8, PIX_Y_W=7, and the default ghost colours.
REQ-033 SHALL instantiate one sub-module, tile_raster: given base tile coordinates and a start pulse, it emits TILE*TILE pixel coordinates and a last flag; it is reused for ERASE and DRAW.

Verification
REQ-034 Reset release, then step_tick with ghosts at (3,2)/(10,5)/(31,15) -> 75 plots, no COL_BG; first plot is (15,10,COL_G1); last plot is (159,79,COL_G3); done at cycle 157-75+... measured per REQ-027 minus skipped erases.
REQ-035 Second step, g1 moves (3,2)->(4,2) -> 25 COL_BG plots at x 15..19, y 10..14, then 25 COL_G1 plots at x 20..24.
REQ-036 step_tick pulsed during busy -> no extra path_enable, and exactly one done.
REQ-037 resetn low mid-DRAW -> vga_plot=0 and busy=0 immediately; the next step draws with no erase.
REQ-038 GHOST_SKIP_UNCHANGED_EN defined, all positions static -> 0 plots, and done follows 3 cycles after WAIT.
